// File: rtl/layer_mem_arbiter.sv
// Two-requester arbiter for the shared layer memory port: round-robin with a bounded burst lock,
// registered memory strobes and tag-routed read returns.
module layer_mem_arbiter #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 20,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [2:0]    r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [2:0]    r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,

  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          acc;
  logic          acc_id;
  logic          acc_lock;
  logic          acc_we;
  logic [2:0]    acc_sel;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // last_q names the requester granted most recently; reset value 1 makes r0 win first.
  logic          last_q, last_d;
  logic          own_vld_q, own_vld_d;
  logic          owner_q, owner_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic          rd_tag_q;

  assign req = {r1_req, r0_req};

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (own_vld_q && req[owner_q]) begin
        if (burst_cnt_q == MaxCnt && req[~owner_q]) begin
          gnt[~owner_q] = 1'b1;
        end else begin
          gnt[owner_q] = 1'b1;
        end
      end else if (req == 2'b11) begin
        gnt[~last_q] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  // A grant is only ever given to a requesting engine, so any grant is an accept.
  assign acc       = |gnt;
  assign acc_id    = gnt[1];
  assign acc_lock  = acc_id ? r1_lock  : r0_lock;
  assign acc_we    = acc_id ? r1_we    : r0_we;
  assign acc_sel   = acc_id ? r1_sel   : r0_sel;
  assign acc_addr  = acc_id ? r1_addr  : r0_addr;
  assign acc_wdata = acc_id ? r1_wdata : r0_wdata;

  always_comb begin
    last_d      = last_q;
    own_vld_d   = 1'b0;
    owner_d     = owner_q;
    burst_cnt_d = 8'd0;
    if (acc) begin
      last_d = acc_id;
      if (acc_lock) begin
        own_vld_d = 1'b1;
        owner_d   = acc_id;
        if (own_vld_q && owner_q == acc_id) begin
          burst_cnt_d = (burst_cnt_q == MaxCnt) ? burst_cnt_q : burst_cnt_q + 8'd1;
        end else begin
          burst_cnt_d = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      own_vld_q   <= 1'b0;
      owner_q     <= 1'b0;
      burst_cnt_q <= 8'd0;
      rd_tag_q    <= 1'b0;
      crd         <= 1'b0;
      cwr         <= 1'b0;
      caddr_rd    <= '0;
      caddr_wr    <= '0;
      cdata_wr    <= '0;
      csel        <= '0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
    end else begin
      last_q      <= last_d;
      own_vld_q   <= own_vld_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      crd         <= acc & ~acc_we;
      cwr         <= acc & acc_we;
      if (acc) begin
        csel     <= acc_sel;
        rd_tag_q <= acc_id;
      end
      if (acc && !acc_we) begin
        caddr_rd <= acc_addr;
      end
      if (acc && acc_we) begin
        caddr_wr <= acc_addr;
        cdata_wr <= acc_wdata;
      end
      // Memory data is valid alongside crd; route it by the tag captured at issue.
      r0_rvalid <= crd & ~rd_tag_q;
      r1_rvalid <= crd & rd_tag_q;
      if (crd && !rd_tag_q) begin
        r0_rdata <= cdata_rd;
      end
      if (crd && rd_tag_q) begin
        r1_rdata <= cdata_rd;
      end
    end
  end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Table-driven bench for layer_mem_arbiter with MAX_BURST = 4 and a combinational memory model.
module tb_layer_mem_arbiter;

  localparam int unsigned AW        = 12;
  localparam int unsigned DW        = 20;
  localparam int unsigned MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r0_lock, r0_we, r0_gnt, r0_rvalid;
  logic [2:0]    r0_sel;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_lock, r1_we, r1_gnt, r1_rvalid;
  logic [2:0]    r1_sel;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  always #5 clk = ~clk;

  layer_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_sel(r0_sel), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_sel(r1_sel), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return (a == 12'h041) ? 20'h01310 : {8'h5A, a};
  endfunction

  assign cdata_rd = crd ? rd_fn(caddr_rd) : '0;

  typedef struct packed {
    logic          rst;
    logic [1:0]    req, lock, we;
    logic [2:0]    s0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [2:0]    s1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [1:0]    gnt;
    logic          crd, cwr;
    logic [AW-1:0] ard, awr;
    logic [DW-1:0] wd;
    logic [2:0]    sel;
    logic [1:0]    rv;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic v(input logic rst, input logic [1:0] req, input logic [1:0] lock,
                   input logic [1:0] we, input logic [2:0] s0, input logic [AW-1:0] a0,
                   input logic [DW-1:0] d0, input logic [2:0] s1, input logic [AW-1:0] a1,
                   input logic [DW-1:0] d1, input logic [1:0] gnt, input logic ecrd,
                   input logic ecwr, input logic [AW-1:0] ard, input logic [AW-1:0] awr,
                   input logic [DW-1:0] wd, input logic [2:0] sel, input logic [1:0] rv,
                   input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    tbl.push_back({rst, req, lock, we, s0, a0, d0, s1, a1, d1,
                   gnt, ecrd, ecwr, ard, awr, wd, sel, rv, rd0, rd1});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0;
    r0_req = 0; r0_lock = 0; r0_we = 0; r0_sel = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_lock = 0; r1_we = 0; r1_sel = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  initial begin
    vec_t t;
    int   waits;
    bit   got;

    // Single read from r0, checked through strobe and return
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h000, 12'h000, 20'h0, 0, 2'b00, 20'h0, 20'h0);
    v(0, 2'b01, 2'b00, 2'b00, 1, 12'h041, 0, 0, 12'h000, 0,
      2'b01, 0, 0, 12'h000, 12'h000, 20'h0, 0, 2'b00, 20'h0, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 1, 0, 12'h041, 12'h000, 20'h0, 1, 2'b00, 20'h0, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h041, 12'h000, 20'h0, 1, 2'b01, 20'h01310, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h041, 12'h000, 20'h0, 1, 2'b00, 20'h01310, 20'h0);
    // Contention without lock: strict alternation, r1 first since r0 won last
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b10, 0, 0, 12'h041, 12'h000, 20'h0, 1, 2'b00, 20'h01310, 20'h0);
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b01, 0, 1, 12'h041, 12'h020, 20'h0000A, 3, 2'b00, 20'h01310, 20'h0);
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b10, 1, 0, 12'h010, 12'h020, 20'h0000A, 2, 2'b00, 20'h01310, 20'h0);
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b01, 0, 1, 12'h010, 12'h020, 20'h0000A, 3, 2'b01, 20'h5A010, 20'h0);
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b10, 1, 0, 12'h010, 12'h020, 20'h0000A, 2, 2'b00, 20'h5A010, 20'h0);
    v(0, 2'b11, 2'b00, 2'b10, 2, 12'h010, 0, 3, 12'h020, 20'h0000A,
      2'b01, 0, 1, 12'h010, 12'h020, 20'h0000A, 3, 2'b01, 20'h5A010, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 1, 0, 12'h010, 12'h020, 20'h0000A, 2, 2'b00, 20'h5A010, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h010, 12'h020, 20'h0000A, 2, 2'b01, 20'h5A010, 20'h0);
    // Burst lock by r1: four grants, forced hand-off to r0, then r1 again
    v(0, 2'b10, 2'b10, 2'b10, 0, 12'h000, 0, 4, 12'h100, 20'h11111,
      2'b10, 0, 0, 12'h010, 12'h020, 20'h0000A, 2, 2'b00, 20'h5A010, 20'h0);
    for (int i = 0; i < 3; i++) begin
      v(0, 2'b11, 2'b10, 2'b10, 5, 12'h200, 0, 4, 12'h100, 20'h11111,
        2'b10, 0, 1, 12'h010, 12'h100, 20'h11111, 4, 2'b00, 20'h5A010, 20'h0);
    end
    v(0, 2'b11, 2'b10, 2'b10, 5, 12'h200, 0, 4, 12'h100, 20'h11111,
      2'b01, 0, 1, 12'h010, 12'h100, 20'h11111, 4, 2'b00, 20'h5A010, 20'h0);
    v(0, 2'b11, 2'b10, 2'b10, 5, 12'h200, 0, 4, 12'h100, 20'h11111,
      2'b10, 1, 0, 12'h200, 12'h100, 20'h11111, 5, 2'b00, 20'h5A010, 20'h0);
    v(0, 2'b11, 2'b10, 2'b10, 5, 12'h200, 0, 4, 12'h100, 20'h11111,
      2'b10, 0, 1, 12'h200, 12'h100, 20'h11111, 4, 2'b01, 20'h5A200, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 1, 12'h200, 12'h100, 20'h11111, 4, 2'b00, 20'h5A200, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h200, 12'h100, 20'h11111, 4, 2'b00, 20'h5A200, 20'h0);
    // Back-to-back: r0 write then r1 read
    v(0, 2'b01, 2'b00, 2'b01, 0, 12'h000, 20'h003FF, 0, 12'h000, 0,
      2'b01, 0, 0, 12'h200, 12'h100, 20'h11111, 4, 2'b00, 20'h5A200, 20'h0);
    v(0, 2'b10, 2'b00, 2'b00, 0, 12'h000, 0, 6, 12'h002, 0,
      2'b10, 0, 1, 12'h200, 12'h000, 20'h003FF, 0, 2'b00, 20'h5A200, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 1, 0, 12'h002, 12'h000, 20'h003FF, 6, 2'b00, 20'h5A200, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h002, 12'h000, 20'h003FF, 6, 2'b10, 20'h5A200, 20'h5A002);
    // Reset while a read is in flight
    v(0, 2'b01, 2'b00, 2'b00, 1, 12'h041, 0, 0, 12'h000, 0,
      2'b01, 0, 0, 12'h002, 12'h000, 20'h003FF, 6, 2'b00, 20'h5A200, 20'h5A002);
    v(1, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 1, 0, 12'h041, 12'h000, 20'h003FF, 1, 2'b00, 20'h5A200, 20'h5A002);
    v(0, 2'b11, 2'b00, 2'b00, 7, 12'h003, 0, 2, 12'h004, 0,
      2'b01, 0, 0, 12'h000, 12'h000, 20'h0, 0, 2'b00, 20'h0, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 1, 0, 12'h003, 12'h000, 20'h0, 7, 2'b00, 20'h0, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h003, 12'h000, 20'h0, 7, 2'b01, 20'h5A003, 20'h0);
    // Uncontended lock past saturation, then forced hand-off and round-robin on release
    v(0, 2'b01, 2'b01, 2'b01, 1, 12'h007, 20'h00007, 0, 12'h000, 0,
      2'b01, 0, 0, 12'h003, 12'h000, 20'h0, 7, 2'b00, 20'h5A003, 20'h0);
    for (int i = 0; i < 5; i++) begin
      v(0, 2'b01, 2'b01, 2'b01, 1, 12'h007, 20'h00007, 0, 12'h000, 0,
        2'b01, 0, 1, 12'h003, 12'h007, 20'h00007, 1, 2'b00, 20'h5A003, 20'h0);
    end
    v(0, 2'b11, 2'b01, 2'b01, 1, 12'h007, 20'h00007, 3, 12'h005, 0,
      2'b10, 0, 1, 12'h003, 12'h007, 20'h00007, 1, 2'b00, 20'h5A003, 20'h0);
    v(0, 2'b11, 2'b01, 2'b01, 1, 12'h007, 20'h00007, 3, 12'h005, 0,
      2'b01, 1, 0, 12'h005, 12'h007, 20'h00007, 3, 2'b00, 20'h5A003, 20'h0);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 1, 12'h005, 12'h007, 20'h00007, 1, 2'b10, 20'h5A003, 20'h5A005);
    v(0, 2'b00, 2'b00, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0,
      2'b00, 0, 0, 12'h005, 12'h007, 20'h00007, 1, 2'b00, 20'h5A003, 20'h5A005);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      #1;
      reset = t.rst;
      r0_req = t.req[0]; r0_lock = t.lock[0]; r0_we = t.we[0];
      r0_sel = t.s0; r0_addr = t.a0; r0_wdata = t.d0;
      r1_req = t.req[1]; r1_lock = t.lock[1]; r1_we = t.we[1];
      r1_sel = t.s1; r1_addr = t.a1; r1_wdata = t.d1;
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 32'({r1_gnt, r0_gnt}), 32'(t.gnt));
      chk($sformatf("v%0d crd", i), 32'(crd), 32'(t.crd));
      chk($sformatf("v%0d cwr", i), 32'(cwr), 32'(t.cwr));
      chk($sformatf("v%0d caddr_rd", i), 32'(caddr_rd), 32'(t.ard));
      chk($sformatf("v%0d caddr_wr", i), 32'(caddr_wr), 32'(t.awr));
      chk($sformatf("v%0d cdata_wr", i), 32'(cdata_wr), 32'(t.wd));
      chk($sformatf("v%0d csel", i), 32'(csel), 32'(t.sel));
      chk($sformatf("v%0d rvalid", i), 32'({r1_rvalid, r0_rvalid}), 32'(t.rv));
      chk($sformatf("v%0d r0_rdata", i), 32'(r0_rdata), 32'(t.rd0));
      chk($sformatf("v%0d r1_rdata", i), 32'(r1_rdata), 32'(t.rd1));
      @(posedge clk);
    end

    // r0 waits behind a fresh r1 lock for exactly MAX_BURST cycles
    #1;
    drive_idle();
    r1_req = 1; r1_lock = 1; r1_we = 1; r1_sel = 2; r1_addr = 12'h0AA; r1_wdata = 20'h12345;
    r0_req = 1; r0_sel = 5; r0_addr = 12'h0BB;
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 4 * MAX_BURST && !got; c++) begin
      @(negedge clk);
      if (r0_gnt) got = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    chk("burst wait granted", 32'(got), 32'd1);
    chk("burst wait cycles", 32'(waits), 32'(MAX_BURST));
    r0_req = 0;
    @(negedge clk);
    chk("handoff regrant r1", 32'({r1_gnt, r0_gnt}), 32'b10);
    chk("handoff read strobe", 32'(crd), 32'd1);
    chk("handoff read addr", 32'(caddr_rd), 32'h0BB);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    chk("handoff r0 rvalid", 32'({r1_rvalid, r0_rvalid}), 32'b01);
    chk("handoff r0 rdata", 32'(r0_rdata), 32'h5A0BB);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
